// File: rtl/exe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exe_pkg : shared opcodes, flag indices and helpers for execute_iter  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package exe_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADC  = 4'd1,
    OP_SUB  = 4'd2,
    OP_SBB  = 4'd3,
    OP_CMP  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_TEST = 4'd8,
    OP_NOT  = 4'd9,
    OP_MUL  = 4'd10,
    OP_IMUL = 4'd11,
    OP_DIV  = 4'd12,
    OP_IDIV = 4'd13
  } exe_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } exe_state_t;

  // Bit positions inside the {CF,PF,ZF,SF,OF} status vector
  localparam int STATUS_CF = 4;
  localparam int STATUS_PF = 3;
  localparam int STATUS_ZF = 2;
  localparam int STATUS_SF = 1;
  localparam int STATUS_OF = 0;

  localparam logic [1:0] OPSIZE_8  = 2'd0;
  localparam logic [1:0] OPSIZE_16 = 2'd1;
  localparam logic [1:0] OPSIZE_32 = 2'd2;

  function automatic logic is_iterative(exe_op_t op);
    return (op == OP_MUL) || (op == OP_IMUL) || (op == OP_DIV) || (op == OP_IDIV);
  endfunction

  function automatic logic [5:0] eff_width(logic [1:0] opsize, int unsigned width);
    logic [5:0] ew;
    case (opsize)
      OPSIZE_8:  ew = 6'd8;
      OPSIZE_16: ew = 6'd16;
      OPSIZE_32: ew = 6'd32;
      default:   ew = 6'd32;
    endcase
    if (width < 32'(ew)) ew = 6'(width);
    return ew;
  endfunction

  function automatic logic [4:0] pack_flags(logic cf, logic pf, logic zf, logic sf, logic of);
    logic [4:0] f;
    f            = '0;
    f[STATUS_CF] = cf;
    f[STATUS_PF] = pf;
    f[STATUS_ZF] = zf;
    f[STATUS_SF] = sf;
    f[STATUS_OF] = of;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/execute_iter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | execute_iter_if : command/result handshake bundle for execute_iter   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface execute_iter_if
  import exe_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  exe_op_t          op;
  logic [1:0]       opsize;
  logic [WIDTH-1:0] opnd0;
  logic [WIDTH-1:0] opnd1;
  logic [WIDTH-1:0] opnd_hi;
  logic [4:0]       status_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;
  logic [4:0]       status_out;
  logic             wr_en;
  logic             div_err;

  modport master (
    output in_valid, op, opsize, opnd0, opnd1, opnd_hi, status_in, out_ready,
    input  in_ready, out_valid, result_lo, result_hi, status_out, wr_en, div_err
  );

  modport slave (
    input  in_valid, op, opsize, opnd0, opnd1, opnd_hi, status_in, out_ready,
    output in_ready, out_valid, result_lo, result_hi, status_out, wr_en, div_err
  );
endinterface
`default_nettype wire

// File: rtl/exe_iter_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | exe_iter_core : shared shift-add multiply / restoring divide datapath|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module exe_iter_core #(
  parameter int WIDTH = 32
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_start,
  input  wire logic             i_step,
  input  wire logic             i_div,
  input  wire logic [5:0]       i_ew,
  input  wire logic [WIDTH-1:0] i_d,
  input  wire logic [WIDTH-1:0] i_lo,
  input  wire logic [WIDTH-1:0] i_hi,
  output logic                  o_last,
  output logic [WIDTH-1:0]      o_lo_nxt,
  output logic [WIDTH-1:0]      o_hi_nxt
);
  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  logic [WIDTH-1:0] r_d, r_lo, r_hi, r_msb;
  logic [5:0]       r_cnt;
  logic             r_div;

  logic [WIDTH-1:0] w_mask;
  logic [WIDTH:0]   w_sum, w_shl;
  logic [WIDTH-1:0] w_mul_lo, w_mul_hi, w_div_lo, w_div_hi, w_dif;
  logic             w_ge;

  assign w_mask = (r_msb << 1) - c_one;

  // Multiply: product bits enter at bit ew-1 so the low half stays aligned at any width
  assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_d} : '0);
  assign w_mul_hi = w_sum[WIDTH:1];
  assign w_mul_lo = (r_lo >> 1) | (w_sum[0] ? r_msb : '0);

  assign w_shl    = {r_hi, |(r_lo & r_msb)};
  assign w_ge     = (w_shl >= {1'b0, r_d});
  assign w_dif    = WIDTH'(w_shl - {1'b0, r_d});
  assign w_div_hi = w_ge ? w_dif : w_shl[WIDTH-1:0];
  assign w_div_lo = ((r_lo << 1) & w_mask) | {{(WIDTH-1){1'b0}}, w_ge};

  assign o_lo_nxt = r_div ? w_div_lo : w_mul_lo;
  assign o_hi_nxt = r_div ? w_div_hi : w_mul_hi;
  assign o_last   = (r_cnt == 6'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_d   <= '0;
      r_lo  <= '0;
      r_hi  <= '0;
      r_msb <= '0;
      r_cnt <= '0;
      r_div <= 1'b0;
    end else if (i_start) begin
      r_d   <= i_d;
      r_lo  <= i_lo;
      r_hi  <= i_hi;
      r_msb <= c_one << (i_ew - 6'd1);
      r_cnt <= i_ew;
      r_div <= i_div;
    end else if (i_step) begin
      r_lo  <= o_lo_nxt;
      r_hi  <= o_hi_nxt;
      r_cnt <= r_cnt - 6'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/execute_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | execute_iter : multi-cycle ALU/MUL/DIV execute stage with x86 flags  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module execute_iter
  import exe_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input wire logic clk,
  input wire logic rst,
  execute_iter_if.slave exe
);
  localparam logic [WIDTH-1:0] c_one = WIDTH'(1);

  exe_state_t r_state, w_state_nxt;

  logic             w_accept, w_iter, w_signed, w_is_div, w_dvz, w_start, w_last;
  logic [5:0]       w_ew;
  logic [WIDTH-1:0] w_mask, w_msb, w_a, w_b, w_h;
  logic [WIDTH:0]   w_cbit, w_add, w_sub;
  logic             w_sa, w_sb, w_sh, w_carry_in;

  assign w_accept   = exe.in_valid && (r_state == S_IDLE);
  assign w_ew       = eff_width(exe.opsize, WIDTH);
  assign w_mask     = {WIDTH{1'b1}} >> (6'(WIDTH) - w_ew);
  assign w_msb      = c_one << (w_ew - 6'd1);
  assign w_cbit     = {w_msb, 1'b0};
  assign w_a        = exe.opnd0 & w_mask;
  assign w_b        = exe.opnd1 & w_mask;
  assign w_h        = exe.opnd_hi & w_mask;
  assign w_sa       = |(w_a & w_msb);
  assign w_sb       = |(w_b & w_msb);
  assign w_sh       = |(w_h & w_msb);
  assign w_iter     = is_iterative(exe.op);
  assign w_signed   = (exe.op == OP_IMUL) || (exe.op == OP_IDIV);
  assign w_is_div   = (exe.op == OP_DIV) || (exe.op == OP_IDIV);
  assign w_dvz      = w_is_div && (w_b == '0);
  assign w_start    = w_accept && w_iter && !w_dvz;
  assign w_carry_in = exe.status_in[STATUS_CF] && ((exe.op == OP_ADC) || (exe.op == OP_SBB));

  // Carry/borrow out of bit ew-1 lands on bit ew of these widened results
  assign w_add = {1'b0, w_a} + {1'b0, w_b} + (WIDTH+1)'(w_carry_in);
  assign w_sub = {1'b0, w_a} - {1'b0, w_b} - (WIDTH+1)'(w_carry_in);

  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_cf, w_alu_of;
  logic [4:0]       w_alu_st;

  always_comb begin
    w_alu_res = '0;
    w_alu_cf  = 1'b0;
    w_alu_of  = 1'b0;
    case (exe.op)
      OP_ADD, OP_ADC: begin
        w_alu_res = w_add[WIDTH-1:0] & w_mask;
        w_alu_cf  = |(w_add & w_cbit);
        w_alu_of  = (w_sa == w_sb) && ((|(w_alu_res & w_msb)) != w_sa);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        w_alu_res = w_sub[WIDTH-1:0] & w_mask;
        w_alu_cf  = |(w_sub & w_cbit);
        w_alu_of  = (w_sa != w_sb) && ((|(w_alu_res & w_msb)) != w_sa);
      end
      OP_AND, OP_TEST: w_alu_res = w_a & w_b;
      OP_OR:           w_alu_res = w_a | w_b;
      OP_XOR:          w_alu_res = w_a ^ w_b;
      OP_NOT:          w_alu_res = ~w_a & w_mask;
      default:         ;
    endcase
    w_alu_st = (exe.op == OP_NOT) ? exe.status_in :
               pack_flags(w_alu_cf, ~^w_alu_res[7:0], (w_alu_res == '0),
                          |(w_alu_res & w_msb), w_alu_of);
  end

  // Signed operations iterate on magnitudes; the signs are kept for the last step
  logic [WIDTH-1:0] w_a_mag, w_b_mag, w_lo_mag, w_hi_mag;
  logic [WIDTH-1:0] w_core_d, w_core_lo, w_core_hi, w_nxt_lo, w_nxt_hi;

  assign w_a_mag   = (w_signed && w_sa) ? ((-w_a) & w_mask) : w_a;
  assign w_b_mag   = (w_signed && w_sb) ? ((-w_b) & w_mask) : w_b;
  assign w_lo_mag  = (w_signed && w_sh) ? ((-w_a) & w_mask) : w_a;
  assign w_hi_mag  = (w_signed && w_sh) ? ((~w_h + WIDTH'(w_a == '0)) & w_mask) : w_h;
  assign w_core_d  = w_is_div ? w_b_mag  : w_a_mag;
  assign w_core_lo = w_is_div ? w_lo_mag : w_b_mag;
  assign w_core_hi = w_is_div ? w_hi_mag : '0;

  exe_iter_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_step   (r_state == S_BUSY),
    .i_div    (w_is_div),
    .i_ew     (w_ew),
    .i_d      (w_core_d),
    .i_lo     (w_core_lo),
    .i_hi     (w_core_hi),
    .o_last   (w_last),
    .o_lo_nxt (w_nxt_lo),
    .o_hi_nxt (w_nxt_hi)
  );

  exe_op_t          r_op;
  logic [WIDTH-1:0] r_mask, r_msb;
  logic             r_neg_q, r_neg_r, r_ovf;
  logic [4:0]       r_stat_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op      <= OP_ADD;
      r_mask    <= '0;
      r_msb     <= '0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_ovf     <= 1'b0;
      r_stat_in <= '0;
    end else if (w_accept) begin
      r_op      <= exe.op;
      r_mask    <= w_mask;
      r_msb     <= w_msb;
      r_neg_q   <= w_signed && (w_is_div ? (w_sh ^ w_sb) : (w_sa ^ w_sb));
      r_neg_r   <= w_signed && w_sh;
      r_ovf     <= (w_hi_mag >= w_b_mag);
      r_stat_in <= exe.status_in;
    end
  end

  logic [WIDTH-1:0] w_c_lo, w_c_hi, w_fin_lo, w_fin_hi, w_hi_ext;
  logic             w_fin_ovf, w_fin_wr, w_fin_de;
  logic [4:0]       w_fin_st;

  assign w_c_lo = w_nxt_lo & r_mask;
  assign w_c_hi = w_nxt_hi & r_mask;

  always_comb begin
    w_fin_lo  = '0;
    w_fin_hi  = '0;
    w_hi_ext  = '0;
    w_fin_ovf = 1'b0;
    w_fin_wr  = 1'b1;
    w_fin_de  = 1'b0;
    w_fin_st  = r_stat_in;
    if ((r_op == OP_MUL) || (r_op == OP_IMUL)) begin
      w_fin_lo  = r_neg_q ? ((-w_c_lo) & r_mask) : w_c_lo;
      w_fin_hi  = r_neg_q ? ((~w_c_hi + WIDTH'(w_c_lo == '0)) & r_mask) : w_c_hi;
      w_hi_ext  = (|(w_fin_lo & r_msb)) ? r_mask : '0;
      w_fin_ovf = (r_op == OP_IMUL) ? (w_fin_hi != w_hi_ext) : (w_fin_hi != '0);
      w_fin_st  = pack_flags(w_fin_ovf, ~^w_fin_lo[7:0], (w_fin_lo == '0),
                             |(w_fin_lo & r_msb), w_fin_ovf);
    end else if (r_ovf || ((r_op == OP_IDIV) &&
                           (r_neg_q ? (w_c_lo > r_msb) : (|(w_c_lo & r_msb))))) begin
      // A negative quotient may reach -2^(ew-1); a positive one must stay below it
      w_fin_wr = 1'b0;
      w_fin_de = 1'b1;
    end else begin
      w_fin_lo = r_neg_q ? ((-w_c_lo) & r_mask) : w_c_lo;
      w_fin_hi = r_neg_r ? ((-w_c_hi) & r_mask) : w_c_hi;
    end
  end

  logic [WIDTH-1:0] r_res_lo, r_res_hi;
  logic [4:0]       r_status;
  logic             r_wr_en, r_div_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_lo  <= '0;
      r_res_hi  <= '0;
      r_status  <= '0;
      r_wr_en   <= 1'b0;
      r_div_err <= 1'b0;
    end else if (w_accept && w_dvz) begin
      r_res_lo  <= '0;
      r_res_hi  <= '0;
      r_status  <= exe.status_in;
      r_wr_en   <= 1'b0;
      r_div_err <= 1'b1;
    end else if (w_accept && !w_iter) begin
      r_res_lo  <= w_alu_res;
      r_res_hi  <= '0;
      r_status  <= w_alu_st;
      r_wr_en   <= (exe.op != OP_CMP) && (exe.op != OP_TEST);
      r_div_err <= 1'b0;
    end else if ((r_state == S_BUSY) && w_last) begin
      r_res_lo  <= w_fin_lo;
      r_res_hi  <= w_fin_hi;
      r_status  <= w_fin_st;
      r_wr_en   <= w_fin_wr;
      r_div_err <= w_fin_de;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_start ? S_BUSY : S_DONE;
      S_BUSY:  if (w_last) w_state_nxt = S_DONE;
      S_DONE:  if (exe.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign exe.in_ready   = (r_state == S_IDLE);
  assign exe.out_valid  = (r_state == S_DONE);
  assign exe.result_lo  = r_res_lo;
  assign exe.result_hi  = r_res_hi;
  assign exe.status_out = r_status;
  assign exe.wr_en      = r_wr_en;
  assign exe.div_err    = r_div_err;

endmodule
`default_nettype wire

// File: tb/tb_execute_iter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_execute_iter : directed self-checking bench for execute_iter      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_execute_iter;
  import exe_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   lat;

  always #5 clk = ~clk;

  execute_iter_if #(.WIDTH(32)) bus ();

  execute_iter #(
    .WIDTH (32)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .exe (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one command and return the number of cycles until out_valid (100 = timeout)
  task automatic run_op(input exe_op_t op, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi, input logic [4:0] st,
                        output int cycles);
    @(negedge clk);
    bus.op        = op;
    bus.opsize    = sz;
    bus.opnd0     = a;
    bus.opnd1     = b;
    bus.opnd_hi   = hi;
    bus.status_in = st;
    bus.in_valid  = 1'b1;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
      bus.in_valid = 1'b0;
    end while (!bus.out_valid && cycles < 100);
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  task automatic expect_out(input string tag, input int got_lat, input int exp_lat,
                            input logic [31:0] lo, input logic [31:0] hi, input logic [4:0] st,
                            input logic wr, input logic de);
    chk({tag, "_lat"}, 64'(got_lat), 64'(exp_lat));
    chk({tag, "_lo"},  64'(bus.result_lo),  64'(lo));
    chk({tag, "_hi"},  64'(bus.result_hi),  64'(hi));
    chk({tag, "_st"},  64'(bus.status_out), 64'(st));
    chk({tag, "_wr"},  64'(bus.wr_en),      64'(wr));
    chk({tag, "_de"},  64'(bus.div_err),    64'(de));
    consume();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.op        = OP_ADD;
    bus.opsize    = 2'd2;
    bus.opnd0     = '0;
    bus.opnd1     = '0;
    bus.opnd_hi   = '0;
    bus.status_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready",  64'(bus.in_ready),   64'd1);
    chk("rst_out_valid", 64'(bus.out_valid),  64'd0);
    chk("rst_lo",        64'(bus.result_lo),  64'd0);
    chk("rst_st",        64'(bus.status_out), 64'd0);
    chk("rst_de",        64'(bus.div_err),    64'd0);
    rst = 1'b0;

    // Flag vectors below are {CF,PF,ZF,SF,OF}
    run_op(OP_ADD, 2'd2, 32'h7FFF_FFFF, 32'h1, 32'h0, 5'b00000, lat);
    expect_out("add32", lat, 1, 32'h8000_0000, 32'h0, 5'b01011, 1'b1, 1'b0);

    run_op(OP_SUB, 2'd0, 32'h0000_AB00, 32'h1234_5601, 32'h0, 5'b00000, lat);
    expect_out("sub8", lat, 1, 32'h0000_00FF, 32'h0, 5'b11010, 1'b1, 1'b0);

    run_op(OP_CMP, 2'd0, 32'h0000_AB00, 32'h1234_5601, 32'h0, 5'b00000, lat);
    chk("cmp8_lat", 64'(lat),            64'd1);
    chk("cmp8_st",  64'(bus.status_out), 64'(5'b11010));
    chk("cmp8_wr",  64'(bus.wr_en),      64'd0);
    consume();

    run_op(OP_ADC, 2'd0, 32'h0000_00FF, 32'h0, 32'h0, 5'b10000, lat);
    expect_out("adc8", lat, 1, 32'h0, 32'h0, 5'b11100, 1'b1, 1'b0);

    run_op(OP_AND, 2'd1, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0, 5'b10001, lat);
    expect_out("and16", lat, 1, 32'h0000_00F0, 32'h0, 5'b01000, 1'b1, 1'b0);

    run_op(OP_NOT, 2'd0, 32'h0000_000F, 32'h0, 32'h0, 5'b01010, lat);
    expect_out("not8", lat, 1, 32'h0000_00F0, 32'h0, 5'b01010, 1'b1, 1'b0);

    run_op(OP_MUL, 2'd2, 32'hFFFF_FFFF, 32'h2, 32'h0, 5'b00000, lat);
    expect_out("mul32", lat, 33, 32'hFFFF_FFFE, 32'h1, 5'b10011, 1'b1, 1'b0);

    run_op(OP_MUL, 2'd0, 32'h10, 32'h10, 32'h0, 5'b00000, lat);
    expect_out("mul8", lat, 9, 32'h0, 32'h1, 5'b11101, 1'b1, 1'b0);

    run_op(OP_IMUL, 2'd0, 32'hFF, 32'h02, 32'h0, 5'b00000, lat);
    expect_out("imul8", lat, 9, 32'hFE, 32'hFF, 5'b00010, 1'b1, 1'b0);

    run_op(OP_IDIV, 2'd1, 32'h0000_FFF9, 32'h2, 32'h0000_FFFF, 5'b10101, lat);
    expect_out("idiv16", lat, 17, 32'h0000_FFFD, 32'h0000_FFFF, 5'b10101, 1'b1, 1'b0);

    run_op(OP_DIV, 2'd1, 32'h64, 32'h7, 32'h0, 5'b00000, lat);
    expect_out("div16", lat, 17, 32'h0E, 32'h02, 5'b00000, 1'b1, 1'b0);

    run_op(OP_DIV, 2'd2, 32'h5, 32'h0, 32'h0, 5'b00110, lat);
    expect_out("div0", lat, 1, 32'h0, 32'h0, 5'b00110, 1'b0, 1'b1);

    run_op(OP_DIV, 2'd0, 32'h00, 32'h1, 32'h01, 5'b00000, lat);
    expect_out("div8ovf", lat, 9, 32'h0, 32'h0, 5'b00000, 1'b0, 1'b1);

    // Consumer stall: outputs and in_ready must hold while out_ready stays low
    run_op(OP_ADD, 2'd0, 32'h1, 32'h2, 32'h0, 5'b00000, lat);
    chk("stall_lat", 64'(lat), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 64'(bus.out_valid),  64'd1);
      chk("stall_ready", 64'(bus.in_ready),   64'd0);
      chk("stall_lo",    64'(bus.result_lo),  64'd3);
      chk("stall_st",    64'(bus.status_out), 64'(5'b01000));
    end
    consume();

    // Reset in the middle of a 32-bit multiply
    @(negedge clk);
    bus.op        = OP_MUL;
    bus.opsize    = 2'd2;
    bus.opnd0     = 32'hFFFF_FFFF;
    bus.opnd1     = 32'h3;
    bus.opnd_hi   = 32'h0;
    bus.status_in = 5'b00000;
    bus.in_valid  = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("midrst_busy", 64'(bus.in_ready), 64'd0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_valid", 64'(bus.out_valid),  64'd0);
    chk("midrst_ready", 64'(bus.in_ready),   64'd1);
    chk("midrst_lo",    64'(bus.result_lo),  64'd0);
    chk("midrst_hi",    64'(bus.result_hi),  64'd0);
    chk("midrst_st",    64'(bus.status_out), 64'd0);
    chk("midrst_wr",    64'(bus.wr_en),      64'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("postrst_ready", 64'(bus.in_ready), 64'd1);

    run_op(OP_ADD, 2'd2, 32'h1, 32'h1, 32'h0, 5'b00000, lat);
    expect_out("postrst_add", lat, 1, 32'h2, 32'h0, 5'b00000, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/execute_iter.md
# execute_iter

Parametrised, multi-cycle successor to the single-cycle execute stage. It accepts one decoded arithmetic command per handshake and performs add, subtract and logic operations in one cycle. MUL/IMUL run as iterative shift-add and DIV/IDIV as iterative restoring division. It sizes operands at 8/16/32 bits (capped at WIDTH), returns the x86 arithmetic status flags, and raises a divide-error flag. It sits between decode and writeback and back-pressures decode while an iterative operation is in flight.

## Interface
- WIDTH, 32, datapath width; legal values 8, 16, 32.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  command present.
- in_ready  out  1  unit can accept; high only in IDLE.
- op  in  4  exe_op_t: ADD, ADC, SUB, SBB, CMP, AND, OR, XOR, TEST, NOT, MUL, IMUL, DIV, IDIV.
- opsize  in  2  effective width: 0 = 8, 1 = 16, 2 = 32. Values above WIDTH clamp to WIDTH; 3 is treated as 2.
- opnd0, opnd1  in  WIDTH  dst/src operands. For DIV, opnd0 is the low dividend half.
- opnd_hi  in  WIDTH  high dividend half (DIV/IDIV only).
- status_in  in  5  {CF,PF,ZF,SF,OF}.
- out_valid  out  1  result valid. Reset 0.
- out_ready  in  1  consumer accepts.
- result_lo, result_hi  out  WIDTH  low result / product-high or remainder. Reset 0.
- status_out  out  5  {CF,PF,ZF,SF,OF}. Reset 0.
- wr_en  out  1  destination write required. Low for CMP and TEST. Reset 0.
- div_err  out  1  #DE: divisor zero or quotient overflow. Reset 0.

## Operation
- States: IDLE, BUSY, DONE.
  - IDLE: in_ready=1.
  - On in_valid & in_ready, operands are latched and masked to the effective width (ew). Single-cycle ops go to DONE. MUL/IMUL/DIV/IDIV go to BUSY with iteration counter = ew.
  - BUSY: one shift-add or restore-subtract step per cycle; counter decrements. When the counter reaches 1, sign fixup is applied and the state moves to DONE.
  - DONE: out_valid=1, all outputs held stable. On out_ready the state returns to IDLE. No accept occurs in the DONE cycle.
- Signed ops use the magnitudes of the operands. The signs are recorded at accept and applied in the final BUSY step: the quotient is negated if the signs differ, and the remainder takes the sign of the dividend.
- Arithmetic is performed at ew bits.
  - CF is the carry or borrow out of bit ew-1.
  - OF is the signed overflow at bit ew-1.
  - SF is bit ew-1 of the result.
  - ZF is set when result[ew-1:0] == 0.
  - PF is the even parity of result[7:0].
- ADC/SBB add or subtract status_in.CF.
- AND, OR, XOR, TEST clear CF and OF.
- NOT leaves status_out equal to status_in.
- MUL: CF=OF=(result_hi != 0). IMUL: CF=OF=(result_hi is not the sign extension of result_lo). SF, ZF and PF are computed from result_lo.
- DIV/IDIV: a zero divisor is detected at accept and the command goes directly to DONE with div_err=1, wr_en=0 and results 0. Quotient overflow is detected at DONE with the same response. Flags pass status_in through unchanged.
- Result bits above ew are driven 0.

## Timing
- Single-cycle op accepted at edge N gives out_valid from N+1.
- Iterative op accepted at edge N gives out_valid from N+ew+1 (32-bit: N+33).
- Divide-by-zero gives out_valid at N+1.
- Throughput: at most one command per 2 cycles (accept, then DONE). Back-to-back accept while DONE is held is forbidden.
- The consumer may stall DONE indefinitely. While stalled, outputs are held and in_ready stays 0.
- rst asserted at any point, including mid-BUSY, immediately forces IDLE, clears the counter and zeroes all outputs. The first accept is possible on the first edge after rst deasserts.
- in_valid while not in_ready is ignored; the producer holds it.

## Structure
- Shared package exe_pkg holds:
  - exe_op_t encoding;
  - STATUS_* bit indices;
  - the opsize constants;
  - the function is_iterative(op).
- Sub-module exe_iter_core: shared shift register and adder for the MUL/DIV step, with start, step and done controls. Everything else lives in the top-level FSM.

## Test plan
- WIDTH=32, ADD 0x7FFFFFFF+1, opsize=2 -> result 0x80000000, OF=1, SF=1, CF=0, ZF=0, PF=1; out_valid one cycle after accept.
- SUB 8-bit 0x00-0x01, opsize=0 -> result_lo 0x000000FF, CF=1, SF=1, wr_en=1. CMP with the same operands -> same flags, wr_en=0.
- MUL 32-bit 0xFFFFFFFF*2 -> hi 0x00000001, lo 0xFFFFFFFE, CF=OF=1; out_valid exactly 33 cycles after accept.
- IDIV 16-bit: dividend hi:lo = 0xFFFF:0xFFF9 (-7), divisor 2 -> quotient 0xFFFD (-3), remainder 0xFFFF (-1), div_err=0.
- DIV by 0 -> div_err=1, wr_en=0 one cycle after accept. DIV 8-bit 0x01:0x00 by 1 (quotient overflow) -> div_err=1 at DONE.
- Assert rst at cycle 10 of a 32-bit MUL -> outputs 0 and in_ready=1 after deassert. Hold out_ready=0 for 5 cycles at DONE -> outputs stable and in_ready=0 throughout.
